// File: rtl/ax_btb_update_writer.sv
// ax_btb_update_writer
//   Producer side of the approximate-BCC BTB write port. Resolved branch results from the
//   IntEx lanes are compacted into an in-order update FIFO. They are drained as bank-conflict-free
//   write requests to the BTB RAM ports. After reset, an invalidation sweep clears every BTB entry
//   through port 0 before any result is accepted.
// Ports
//   clk, rst          clock, synchronous active-high reset
//   in_valid_i        per-lane result valid
//   in_index_i        per-lane BTB index
//   in_tag_i          per-lane tag
//   in_data_i         per-lane compressed target
//   wr_en_o           per-port write strobe
//   wr_index_o        per-port write index
//   wr_tag_o          per-port write tag
//   wr_data_o         per-port write target
//   wr_valid_o        per-port entry valid bit (0 during sweep)
//   stall_o           upstream must hold off new results
//   init_busy_o       invalidation sweep in progress
//   overflow_err_o    sticky: at least one result was dropped
module ax_btb_update_writer #(
    parameter int unsigned IN_WIDTH   = 2,
    parameter int unsigned OUT_WIDTH  = 2,
    parameter int unsigned INDEX_BITS = 9,
    parameter int unsigned BANK_BITS  = 1,
    parameter int unsigned TAG_BITS   = 7,
    parameter int unsigned DATA_BITS  = 12,
    parameter int unsigned DEPTH      = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [IN_WIDTH-1:0]             in_valid_i,
    input  logic [IN_WIDTH*INDEX_BITS-1:0]  in_index_i,
    input  logic [IN_WIDTH*TAG_BITS-1:0]    in_tag_i,
    input  logic [IN_WIDTH*DATA_BITS-1:0]   in_data_i,
    output logic [OUT_WIDTH-1:0]            wr_en_o,
    output logic [OUT_WIDTH*INDEX_BITS-1:0] wr_index_o,
    output logic [OUT_WIDTH*TAG_BITS-1:0]   wr_tag_o,
    output logic [OUT_WIDTH*DATA_BITS-1:0]  wr_data_o,
    output logic [OUT_WIDTH-1:0]            wr_valid_o,
    output logic                            stall_o,
    output logic                            init_busy_o,
    output logic                            overflow_err_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [INDEX_BITS-1:0] SWEEP_LAST = '1;

    typedef struct packed {
        logic [INDEX_BITS-1:0] index;
        logic [TAG_BITS-1:0]   tag;
        logic [DATA_BITS-1:0]  data;
    } entry_t;

    typedef enum logic {
        S_INIT = 1'b0,
        S_RUN  = 1'b1
    } state_e;

    state_e                state_q, state_d;
    logic [INDEX_BITS-1:0] sweep_q, sweep_d;
    logic [PTR_W-1:0]      head_q, head_d;
    logic [PTR_W-1:0]      tail_q, tail_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic                  overflow_q, overflow_d;
    entry_t                mem_q [DEPTH];
    entry_t                mem_d [DEPTH];

    logic [CNT_W-1:0]      popped;
    logic [CNT_W-1:0]      pushed;
    logic [CNT_W-1:0]      free;
    logic                  chain;
    logic                  ok;
    entry_t                cand;
    entry_t                lane_ent;

    // Write port drive: sweep on port 0, or in-order bank-conflict-free FIFO head candidates.
    always_comb begin
        popped     = '0;
        chain      = 1'b1;
        ok         = 1'b0;
        cand       = '0;
        wr_en_o    = '0;
        wr_index_o = '0;
        wr_tag_o   = '0;
        wr_data_o  = '0;
        wr_valid_o = '0;
        if (!rst && state_q == S_INIT) begin
            wr_en_o[0]                  = 1'b1;
            wr_index_o[INDEX_BITS-1:0]  = sweep_q;
        end else if (!rst && state_q == S_RUN) begin
            for (int k = 0; k < int'(OUT_WIDTH); k++) begin
                cand = mem_q[head_q + PTR_W'(k)];
                ok   = chain && (CNT_W'(k) < count_q);
                // chain guarantees every earlier candidate was taken, so compare against all of them
                for (int j = 0; j < k; j++) begin
                    if (mem_q[head_q + PTR_W'(j)].index[BANK_BITS-1:0] == cand.index[BANK_BITS-1:0]) begin
                        ok = 1'b0;
                    end
                end
                chain = ok;
                if (ok) begin
                    popped                                  = popped + CNT_W'(1);
                    wr_en_o[k]                              = 1'b1;
                    wr_valid_o[k]                           = 1'b1;
                    wr_index_o[k*INDEX_BITS +: INDEX_BITS]  = cand.index;
                    wr_tag_o[k*TAG_BITS +: TAG_BITS]        = cand.tag;
                    wr_data_o[k*DATA_BITS +: DATA_BITS]     = cand.data;
                end
            end
        end
    end

    // Next state: sweep progress, lane compaction into the FIFO, pointer and count update.
    always_comb begin
        state_d    = state_q;
        sweep_d    = sweep_q;
        overflow_d = overflow_q;
        mem_d      = mem_q;
        pushed     = '0;
        lane_ent   = '0;
        // a slot popped this cycle is already free for this cycle's push
        free       = CNT_W'(DEPTH) - count_q + popped;
        case (state_q)
            S_INIT: begin
                sweep_d = sweep_q + INDEX_BITS'(1);
                if (sweep_q == SWEEP_LAST) begin
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                for (int l = 0; l < int'(IN_WIDTH); l++) begin
                    if (in_valid_i[l]) begin
                        lane_ent.index = in_index_i[l*INDEX_BITS +: INDEX_BITS];
                        lane_ent.tag   = in_tag_i[l*TAG_BITS +: TAG_BITS];
                        lane_ent.data  = in_data_i[l*DATA_BITS +: DATA_BITS];
                        if (pushed < free) begin
                            mem_d[tail_q + PTR_W'(pushed)] = lane_ent;
                            pushed = pushed + CNT_W'(1);
                        end else begin
                            overflow_d = 1'b1;
                        end
                    end
                end
            end
            default: ;
        endcase
        count_d = count_q + pushed - popped;
        head_d  = head_q + PTR_W'(popped);
        tail_d  = tail_q + PTR_W'(pushed);
    end

    // Control state; reset flushes the FIFO and restarts the sweep.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_INIT;
            sweep_q    <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            sweep_q    <= sweep_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            assert (count_d <= CNT_W'(DEPTH));
        end
    end

    // FIFO storage; contents outside [head, head+count) are don't-care, so no reset.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign init_busy_o    = rst || (state_q == S_INIT);
    assign stall_o        = rst || (state_q == S_INIT) || (count_q > CNT_W'(DEPTH - IN_WIDTH));
    assign overflow_err_o = overflow_q;

endmodule

// File: tb/tb_ax_btb_update_writer.sv
// Testbench for ax_btb_update_writer: queue-based reference model with a scoreboard monitor.
module tb_ax_btb_update_writer;

    localparam int unsigned IW    = 2;
    localparam int unsigned OW    = 2;
    localparam int unsigned IB    = 6;
    localparam int unsigned BB    = 1;
    localparam int unsigned TB    = 7;
    localparam int unsigned DB    = 12;
    localparam int unsigned DEPTH = 8;

    logic clk = 1'b1;
    always #5 clk = ~clk;

    logic               rst;
    logic [IW-1:0]      in_valid;
    logic [IW*IB-1:0]   in_index;
    logic [IW*TB-1:0]   in_tag;
    logic [IW*DB-1:0]   in_data;
    logic [OW-1:0]      wr_en;
    logic [OW*IB-1:0]   wr_index;
    logic [OW*TB-1:0]   wr_tag;
    logic [OW*DB-1:0]   wr_data;
    logic [OW-1:0]      wr_valid;
    logic               stall;
    logic               init_busy;
    logic               overflow_err;

    ax_btb_update_writer #(
        .IN_WIDTH(IW), .OUT_WIDTH(OW), .INDEX_BITS(IB), .BANK_BITS(BB),
        .TAG_BITS(TB), .DATA_BITS(DB), .DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid_i(in_valid), .in_index_i(in_index), .in_tag_i(in_tag), .in_data_i(in_data),
        .wr_en_o(wr_en), .wr_index_o(wr_index), .wr_tag_o(wr_tag), .wr_data_o(wr_data),
        .wr_valid_o(wr_valid), .stall_o(stall), .init_busy_o(init_busy),
        .overflow_err_o(overflow_err)
    );

    typedef struct packed {
        logic [IB-1:0] idx;
        logic [TB-1:0] tag;
        logic [DB-1:0] data;
    } ent_t;

    typedef struct packed {
        logic [OW-1:0]         en;
        logic [OW-1:0][IB-1:0] idx;
        logic [OW-1:0][TB-1:0] tag;
        logic [OW-1:0][DB-1:0] data;
        logic [OW-1:0]         vld;
        logic                  stall;
        logic                  busy;
        logic                  ovf;
        logic                  ovf_chk;
    } exp_t;

    // Reference model state: mode 0 = before first reset, 1 = sweeping, 2 = running.
    ent_t mq[$];
    exp_t eq[$];
    int   mode = 0;
    int   sweep = 0;
    bit   movf = 1'b0;
    bit   movf_known = 1'b0;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic ent_t rnd_ent(input bit bank0);
        ent_t e;
        e.idx  = IB'($urandom);
        e.tag  = TB'($urandom);
        e.data = DB'($urandom);
        if (bank0) e.idx[BB-1:0] = '0;
        return e;
    endfunction

    function automatic ent_t mk(input logic [IB-1:0] i);
        ent_t e;
        e      = rnd_ent(1'b0);
        e.idx  = i;
        return e;
    endfunction

    function automatic bit model_stall();
        return (mode != 2) || (mq.size() > int'(DEPTH - IW));
    endfunction

    // Drive one cycle of inputs, record what the write ports must show this cycle, advance the model.
    task automatic step(input logic r, input logic [IW-1:0] v, input ent_t l0, input ent_t l1);
        exp_t e;
        ent_t ln[IW];
        int   taken;
        bit   clash;
        ln[0]    = l0;
        ln[1]    = l1;
        rst      = r;
        in_valid = v;
        in_index = {l1.idx, l0.idx};
        in_tag   = {l1.tag, l0.tag};
        in_data  = {l1.data, l0.data};

        e         = '0;
        e.ovf     = movf;
        e.ovf_chk = movf_known;
        if (r) begin
            e.stall    = 1'b1;
            e.busy     = 1'b1;
            mode       = 1;
            sweep      = 0;
            mq.delete();
            movf       = 1'b0;
            movf_known = 1'b1;
        end else if (mode == 1) begin
            e.en[0]  = 1'b1;
            e.idx[0] = IB'(sweep);
            e.stall  = 1'b1;
            e.busy   = 1'b1;
            sweep++;
            if (sweep == (1 << IB)) mode = 2;
        end else begin
            e.stall = model_stall();
            taken   = 0;
            for (int k = 0; k < int'(OW); k++) begin
                if (k >= mq.size()) break;
                clash = 1'b0;
                for (int j = 0; j < k; j++)
                    if (mq[j].idx[BB-1:0] == mq[k].idx[BB-1:0]) clash = 1'b1;
                if (clash) break;
                e.en[k]   = 1'b1;
                e.vld[k]  = 1'b1;
                e.idx[k]  = mq[k].idx;
                e.tag[k]  = mq[k].tag;
                e.data[k] = mq[k].data;
                taken++;
            end
            for (int k = 0; k < taken; k++) void'(mq.pop_front());
            for (int l = 0; l < int'(IW); l++) begin
                if (v[l]) begin
                    if (mq.size() < int'(DEPTH)) mq.push_back(ln[l]);
                    else movf = 1'b1;
                end
            end
        end
        eq.push_back(e);
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: compares the DUT outputs mid-cycle against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (eq.size() > 0) begin
            e = eq.pop_front();
            chk("wr_en", 32'(wr_en), 32'(e.en));
            for (int k = 0; k < int'(OW); k++) begin
                if (e.en[k]) begin
                    chk($sformatf("wr_index[%0d]", k), 32'(wr_index[k*IB +: IB]), 32'(e.idx[k]));
                    chk($sformatf("wr_tag[%0d]", k),   32'(wr_tag[k*TB +: TB]),   32'(e.tag[k]));
                    chk($sformatf("wr_data[%0d]", k),  32'(wr_data[k*DB +: DB]),  32'(e.data[k]));
                    chk($sformatf("wr_valid[%0d]", k), 32'(wr_valid[k]),          32'(e.vld[k]));
                end
            end
            chk("stall", 32'(stall), 32'(e.stall));
            chk("init_busy", 32'(init_busy), 32'(e.busy));
            if (e.ovf_chk) chk("overflow_err", 32'(overflow_err), 32'(e.ovf));
        end
    end

    initial begin
        ent_t z;
        logic [IW-1:0] v;
        logic r;
        z = '0;
        rst = 1'b1;
        in_valid = '0;
        in_index = '0;
        in_tag   = '0;
        in_data  = '0;

        // reset, then full sweep with junk on the input lanes (must be ignored)
        step(1'b1, 2'b00, z, z);
        repeat (1 << IB) step(1'b0, 2'($urandom), rnd_ent(1'b0), rnd_ent(1'b0));

        // different banks: both written together next cycle
        step(1'b0, 2'b11, mk(6'h10), mk(6'h21));
        repeat (3) step(1'b0, 2'b00, z, z);

        // same bank: written on port 0 in two successive cycles
        step(1'b0, 2'b11, mk(6'h10), mk(6'h20));
        repeat (3) step(1'b0, 2'b00, z, z);

        // lane gap: only lane 1 valid
        step(1'b0, 2'b10, rnd_ent(1'b0), mk(6'h05));
        repeat (2) step(1'b0, 2'b00, z, z);

        // all bank 0 at two per cycle: fills to DEPTH, then drops a lane
        repeat (8) step(1'b0, 2'b11, rnd_ent(1'b1), rnd_ent(1'b1));

        // drain to 5 queued, then reset: none of them may ever be written
        for (int i = 0; i < 20 && mq.size() > 5; i++) step(1'b0, 2'b00, z, z);
        step(1'b1, 2'b11, rnd_ent(1'b0), rnd_ent(1'b0));
        repeat (1 << IB) step(1'b0, 2'($urandom), rnd_ent(1'b0), rnd_ent(1'b0));

        // random traffic, mostly honouring stall, occasional reset
        repeat (600) begin
            v = 2'($urandom);
            if (model_stall() && ($urandom_range(0, 7) != 0)) v = 2'b00;
            r = ($urandom_range(0, 299) == 0);
            step(r, v, rnd_ent($urandom_range(0, 2) == 0), rnd_ent($urandom_range(0, 2) == 0));
        end
        repeat (12) step(1'b0, 2'b00, z, z);

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(eq.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
